serial_cmp_ctrl: RTL

//   Control-plus-datapath stage placed after the pair of 8-bit PISO shift registers in the

---
 rtl/cmp_pkg.sv | 26 ++
 rtl/serial_mag_cell.sv | 43 ++++
 rtl/serial_cmp_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared state encodings and defaults for the serial magnitude comparator
package cmp_pkg;

    localparam int CMP_WIDTH_DEF    = 8;
    localparam int CMP_PIPE_DLY_DEF = 2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_CMP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_WAIT = ST_WAIT,
        S_CMP  = ST_CMP,
        S_DONE = ST_DONE
    } cmp_state_e;

    // Counter width that stays legal (>= 1 bit) for single-count ranges.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_mag_cell.sv
// rtl/serial_mag_cell.sv - running LSB-first magnitude flags; later bits override earlier ones
module serial_mag_cell
    import cmp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic run_gt_nxt,
    output logic run_lt_nxt
);

    logic run_gt_q, run_lt_q;
    logic run_gt_d, run_lt_d;

    always_comb begin
        run_gt_d = run_gt_q;
        run_lt_d = run_lt_q;
        if (a_bit && !b_bit) begin
            run_gt_d = 1'b1;
            run_lt_d = 1'b0;
        end else if (!a_bit && b_bit) begin
            run_gt_d = 1'b0;
            run_lt_d = 1'b1;
        end
    end

    assign run_gt_nxt = run_gt_d;
    assign run_lt_nxt = run_lt_d;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            run_gt_q <= 1'b0;
            run_lt_q <= 1'b0;
        end else if (en) begin
            run_gt_q <= run_gt_d;
            run_lt_q <= run_lt_d;
        end
    end

endmodule

// File: rtl/serial_cmp_ctrl.sv
// rtl/serial_cmp_ctrl.sv - sequences upstream PISO load, compares their serial streams, holds gt/eq/lt
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH    = CMP_WIDTH_DEF,
    parameter int PIPE_DLY = CMP_PIPE_DLY_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic a_bit,
    input  logic b_bit,
    output logic load_o,
    output logic busy,
    output logic done,
    output logic gt,
    output logic eq,
    output logic lt
);

    localparam int CW = cnt_width(WIDTH);
    localparam int WW = cnt_width(PIPE_DLY);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'((PIPE_DLY > 1) ? PIPE_DLY - 2 : 0);

    cmp_state_e    state_q, state_d;
    logic [CW-1:0] bit_cnt_q;
    logic [WW-1:0] wait_cnt_q;
    logic          load_q, busy_q, done_q;
    logic          gt_q, eq_q, lt_q;
    logic          run_gt_nxt, run_lt_nxt;

    serial_mag_cell u_mag (
        .clk        (clk),
        .reset      (reset),
        .clr        (state_q == S_LOAD),
        .en         (state_q == S_CMP),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .run_gt_nxt (run_gt_nxt),
        .run_lt_nxt (run_lt_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = (PIPE_DLY > 1) ? S_WAIT : S_CMP;
            S_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = S_CMP;
            S_CMP:   if (bit_cnt_q == BIT_LAST) state_d = S_DONE;
            S_DONE:  state_d = start ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are glitch-free Moore outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= (state_d == S_LOAD);
            busy_q  <= (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_CMP);
            done_q  <= (state_d == S_DONE);
            case (state_q)
                S_LOAD: begin
                    bit_cnt_q  <= '0;
                    wait_cnt_q <= '0;
                end
                S_WAIT: wait_cnt_q <= wait_cnt_q + WW'(1);
                S_CMP: begin
                    if (bit_cnt_q != BIT_LAST) begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end else begin
                        gt_q <= run_gt_nxt;
                        lt_q <= run_lt_nxt;
                        eq_q <= ~(run_gt_nxt | run_lt_nxt);
                    end
                end
                default: ;
            endcase
        end
    end

    assign load_o = load_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign gt     = gt_q;
    assign eq     = eq_q;
    assign lt     = lt_q;

endmodule
